// File: rtl/seq_detector_param_if.sv
// Serial bit path bundle for the pattern detector: stream inputs,
// pattern/counter controls and the match outputs.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) ();

  logic               w;
  logic               w_valid;
  logic               overlap_en;
  logic [PAT_LEN-1:0] pat_in;
  logic               pat_load;
  logic               cnt_clr;
  logic               z;
  logic               z_reg;
  logic [CNT_W-1:0]   match_cnt;
  logic [PAT_LEN-1:0] pat_q;

  modport master (
    output w, w_valid, overlap_en, pat_in, pat_load, cnt_clr,
    input  z, z_reg, match_cnt, pat_q
  );

  modport slave (
    input  w, w_valid, overlap_en, pat_in, pat_load, cnt_clr,
    output z, z_reg, match_cnt, pat_q
  );

endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlap/non-overlap matching, Mealy and registered match outputs and a
// saturating match counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no history bits collected (fill == 0)
// ST_PART  | some history collected, not yet enough to compare
// ST_FULL  | PAT_LEN-1 history bits held; next accepted bit can match
module seq_detector_param #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1101,
  parameter int                 CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  seq_detector_param_if.slave  bus
);

  localparam int HW = PAT_LEN - 1;
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] pat_r;
  logic [CNT_W-1:0]   cnt_q;
  logic               z_reg_q;
  logic               accepted;
  logic               z_c;
  logic [PAT_LEN-1:0] window;

  // Match decode: the candidate word is the held history plus the incoming bit.
  always_comb begin
    accepted = bus.w_valid & ~bus.pat_load;
    window   = {hist_q, bus.w};
    z_c      = accepted & (state_q == ST_FULL) & (window == pat_r);
  end

  // Next history/fill/state; a load or a consumed match restarts collection.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (bus.pat_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accepted) begin
      if (z_c && !bus.overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[HW-1:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end
    end
    if (fill_d == '0) begin
      state_d = ST_EMPTY;
    end else if (fill_d == FILL_MAX) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PART;
    end
  end

  // State, history and fill registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // Pattern register, reloaded on pat_load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_r <= PAT_INIT;
    end else if (bus.pat_load) begin
      pat_r <= bus.pat_in;
    end
  end

  // Registered match: the Mealy output delayed by one clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      z_reg_q <= 1'b0;
    end else begin
      z_reg_q <= z_c;
    end
  end

  // Saturating match counter; clear takes priority over a coincident match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (z_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.z         = z_c;
  assign bus.z_reg     = z_reg_q;
  assign bus.match_cnt = cnt_q;
  assign bus.pat_q     = pat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, hand-written corner sequences
// and a randomized run against a bit-queue reference model. Two instances
// share stimulus: an 8-bit counter and a 2-bit counter for saturation.
module tb_seq_detector_param;

  localparam int          PL   = 4;
  localparam logic [3:0]  INIT = 4'b1101;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_LEN(PL), .CNT_W(8)) b8 ();
  seq_detector_param_if #(.PAT_LEN(PL), .CNT_W(2)) b2 ();

  seq_detector_param #(.PAT_LEN(PL), .PAT_INIT(INIT), .CNT_W(8)) dut8 (
    .clk(clk), .resetn(resetn), .bus(b8.slave));
  seq_detector_param #(.PAT_LEN(PL), .PAT_INIT(INIT), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(b2.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: accepted bits since the last restart, current pattern, counts.
  bit         mq[$];
  logic [3:0] m_pat = INIT;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;

  typedef struct {
    bit         rst;
    bit         v, w, ov, ld;
    logic [3:0] pi;
    bit         clr;
    bit         ez;
    logic [7:0] ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_z(input bit v, input bit w, input bit ld);
    int val;
    if (!v || ld || mq.size() < PL - 1) return 1'b0;
    val = 0;
    for (int i = mq.size() - (PL - 1); i < mq.size(); i++) val = val * 2 + int'(mq[i]);
    val = val * 2 + int'(w);
    return val == int'(m_pat);
  endfunction

  task automatic drive(input bit v, input bit w, input bit ov, input bit ld,
                       input logic [3:0] pi, input bit clr);
    b8.w_valid = v;  b8.w = w;  b8.overlap_en = ov;  b8.pat_load = ld;
    b8.pat_in  = pi; b8.cnt_clr = clr;
    b2.w_valid = v;  b2.w = w;  b2.overlap_en = ov;  b2.pat_load = ld;
    b2.pat_in  = pi; b2.cnt_clr = clr;
  endtask

  task automatic step(input bit v, input bit w, input bit ov, input bit ld,
                      input logic [3:0] pi, input bit clr,
                      output bit dz, output logic [7:0] dcnt);
    bit mz;
    @(negedge clk);
    drive(v, w, ov, ld, pi, clr);
    #1;
    mz = model_z(v, w, ld);
    check("z8", {31'd0, b8.z}, {31'd0, mz});
    check("z2", {31'd0, b2.z}, {31'd0, mz});
    dz = b8.z;
    @(posedge clk);
    if (ld) begin
      m_pat = pi;
      mq.delete();
    end else if (v) begin
      if (mz && !ov) begin
        mq.delete();
      end else begin
        mq.push_back(w);
        if (mq.size() > PL) void'(mq.pop_front());
      end
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (mz) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    #1;
    check("z_reg8", {31'd0, b8.z_reg}, {31'd0, mz});
    check("z_reg2", {31'd0, b2.z_reg}, {31'd0, mz});
    check("cnt8", {24'd0, b8.match_cnt}, m_cnt8);
    check("cnt2", {30'd0, b2.match_cnt}, m_cnt2);
    check("pat_q", {28'd0, b8.pat_q}, {28'd0, m_pat});
    dcnt = b8.match_cnt;
  endtask

  // Asserts reset while presenting a bit that would otherwise be accepted.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst_z", {31'd0, b8.z}, 0);
    check("rst_z_reg", {31'd0, b8.z_reg}, 0);
    check("rst_cnt8", {24'd0, b8.match_cnt}, 0);
    check("rst_cnt2", {30'd0, b2.match_cnt}, 0);
    check("rst_pat_q", {28'd0, b8.pat_q}, {28'd0, INIT});
    mq.delete();
    m_pat  = INIT;
    m_cnt8 = 0;
    m_cnt2 = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_z", {31'd0, b2.z}, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    resetn = 1'b1;
  endtask

  task automatic add(input bit rst, input bit v, input bit w, input bit ov, input bit ld,
                     input logic [3:0] pi, input bit ez, input logic [7:0] ecnt);
    vec_t e;
    e.rst = rst; e.v = v; e.w = w; e.ov = ov; e.ld = ld; e.pi = pi;
    e.clr = 1'b0; e.ez = ez; e.ecnt = ecnt;
    tbl.push_back(e);
  endtask

  initial begin
    bit         dz;
    logic [7:0] dcnt;
    int         exp2 [6] = '{1, 2, 3, 3, 3, 3};
    int         k;

    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);

    // Overlap, stream 1101101: hits on bits 4 and 7
    add(1,1,1,1,0,4'h0,0,0); add(0,1,1,1,0,4'h0,0,0); add(0,1,0,1,0,4'h0,0,0);
    add(0,1,1,1,0,4'h0,1,1); add(0,1,1,1,0,4'h0,0,1); add(0,1,0,1,0,4'h0,0,1);
    add(0,1,1,1,0,4'h0,1,2);
    // Non-overlap, same stream: hit on bit 4 only
    add(1,1,1,0,0,4'h0,0,0); add(0,1,1,0,0,4'h0,0,0); add(0,1,0,0,0,4'h0,0,0);
    add(0,1,1,0,0,4'h0,1,1); add(0,1,1,0,0,4'h0,0,1); add(0,1,0,0,0,4'h0,0,1);
    add(0,1,1,0,0,4'h0,0,1);
    // Valid gaps carrying misleading data
    add(1,1,1,1,0,4'h0,0,0); add(0,0,1,1,0,4'h0,0,0); add(0,1,1,1,0,4'h0,0,0);
    add(0,0,0,1,0,4'h0,0,0); add(0,1,0,1,0,4'h0,0,0); add(0,0,1,1,0,4'h0,0,0);
    add(0,1,1,1,0,4'h0,1,1);
    // Pattern load mid-stream; the loading cycle would have completed 1101
    add(1,1,1,1,0,4'h0,0,0); add(0,1,1,1,0,4'h0,0,0); add(0,1,0,1,0,4'h0,0,0);
    add(0,1,1,1,1,4'b0110,0,0);
    add(0,1,0,1,0,4'h0,0,0); add(0,1,1,1,0,4'h0,0,0); add(0,1,1,1,0,4'h0,0,0);
    add(0,1,0,1,0,4'h0,1,1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].v, tbl[i].w, tbl[i].ov, tbl[i].ld, tbl[i].pi, tbl[i].clr, dz, dcnt);
      check($sformatf("tbl%0d_z", i), {31'd0, dz}, {31'd0, tbl[i].ez});
      check($sformatf("tbl%0d_cnt", i), {24'd0, dcnt}, {24'd0, tbl[i].ecnt});
    end

    // Saturation of the 2-bit counter, then clear against a coincident match
    do_reset();
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    step(1,0,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    check("sat_cnt2_0", {30'd0, b2.match_cnt}, exp2[0]);
    for (int m = 1; m < 6; m++) begin
      step(1,1,1,0,4'h0,0,dz,dcnt); step(1,0,1,0,4'h0,0,dz,dcnt);
      step(1,1,1,0,4'h0,0,dz,dcnt);
      check($sformatf("sat_cnt2_%0d", m), {30'd0, b2.match_cnt}, exp2[m]);
    end
    check("sat_cnt8", {24'd0, dcnt}, 6);
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,0,1,0,4'h0,0,dz,dcnt);
    step(1,1,1,0,4'h0,1,dz,dcnt);
    check("clr_hit_z", {31'd0, dz}, 1);
    check("clr_hit_cnt8", {24'd0, dcnt}, 0);
    check("clr_hit_cnt2", {30'd0, b2.match_cnt}, 0);
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,0,1,0,4'h0,0,dz,dcnt);
    step(1,1,1,0,4'h0,0,dz,dcnt);
    check("after_clr_cnt8", {24'd0, dcnt}, 1);

    // Reset mid-sequence while the history would complete a match
    do_reset();
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    step(1,0,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    check("pre_rst_cnt", {24'd0, dcnt}, 1);
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    step(1,0,1,0,4'h0,0,dz,dcnt);
    do_reset();
    step(1,1,1,0,4'h0,0,dz,dcnt);
    check("post_rst_first_z", {31'd0, dz}, 0);
    step(1,1,1,0,4'h0,0,dz,dcnt); step(1,1,1,0,4'h0,0,dz,dcnt);
    step(1,0,1,0,4'h0,0,dz,dcnt);
    check("post_rst_nohit_z", {31'd0, dz}, 0);
    step(1,1,1,0,4'h0,0,dz,dcnt);
    check("post_rst_hit_z", {31'd0, dz}, 1);
    check("post_rst_hit_cnt", {24'd0, dcnt}, 1);

    // Randomized run against the model
    do_reset();
    k = 0;
    for (int c = 0; c < 3000; c++) begin
      bit ov_r;
      ov_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(($urandom_range(0, 9) < 8), 1'($urandom), ov_r,
           ($urandom_range(0, 49) == 0), 4'($urandom),
           ($urandom_range(0, 59) == 0), dz, dcnt);
      if (dz) k++;
    end
    check("rand_saw_matches", {31'd0, (k > 10)}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
